// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the hazard controller: FSM encoding, the $zero
// register number, the default register-address width and the control bundle.
package cpu_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pcStall;
    logic ifIdStall;
    logic ifIdFlush;
    logic idExFlush;
    logic exMemStall;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle for the hazard controller. The pipeline drives
// through the master modport; the hazard controller uses the slave modport.
interface hazard_ctrl_unit_if #(
  parameter int ADDR_W = cpu_pkg::DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] IF_ID_RSaddr_i;
  logic [ADDR_W-1:0] IF_ID_RTaddr_i;
  logic              IF_ID_useRT_i;
  logic [ADDR_W-1:0] ID_EX_RTaddr_i;
  logic              ID_EX_MemRead_i;
  logic              branch_taken_i;
  logic              mem_req_i;
  logic              mem_ready_i;
  logic              PC_stall_o;
  logic              IF_ID_stall_o;
  logic              IF_ID_flush_o;
  logic              ID_EX_flush_o;
  logic              EX_MEM_stall_o;

  modport master (
    output IF_ID_RSaddr_i, IF_ID_RTaddr_i, IF_ID_useRT_i,
    output ID_EX_RTaddr_i, ID_EX_MemRead_i,
    output branch_taken_i, mem_req_i, mem_ready_i,
    input  PC_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_flush_o, EX_MEM_stall_o
  );

  modport slave (
    input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, IF_ID_useRT_i,
    input  ID_EX_RTaddr_i, ID_EX_MemRead_i,
    input  branch_taken_i, mem_req_i, mem_ready_i,
    output PC_stall_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_flush_o, EX_MEM_stall_o
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// CNT_W-wide event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush and memory freeze.
// Define HAZARD_PERF_EN to add the saturating stall/flush performance counters.
module hazard_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hazard_ctrl_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  hz_state_e state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  hz_ctrl_t   ctrl;
  logic       luHit;
  logic       freeze;

  assign luHit = hz.ID_EX_MemRead_i
              && (hz.ID_EX_RTaddr_i != ADDR_W'(REG_ZERO))
              && ((hz.ID_EX_RTaddr_i == hz.IF_ID_RSaddr_i)
                  || (hz.IF_ID_useRT_i && (hz.ID_EX_RTaddr_i == hz.IF_ID_RTaddr_i)));

  // Reset gates the freeze term so a stuck memory handshake cannot hold the pipe.
  assign freeze = rst_i && hz.mem_req_i && !hz.mem_ready_i;

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (!rst_i) begin
      ctrl = '0;
    end else if (freeze) begin
      ctrl.pcStall    = 1'b1;
      ctrl.ifIdStall  = 1'b1;
      ctrl.exMemStall = 1'b1;
    end else if (hz.branch_taken_i) begin
      ctrl.ifIdFlush = 1'b1;
      ctrl.idExFlush = 1'b1;
      state_d        = HZ_RUN;
      bcnt_d         = '0;
    end else if (state_q == HZ_LU_STALL) begin
      // ID/EX already carries a bubble, so the ID instruction is not re-checked here.
      ctrl.pcStall   = 1'b1;
      ctrl.ifIdStall = 1'b1;
      ctrl.idExFlush = 1'b1;
      bcnt_d         = bcnt_q - 3'd1;
      if (bcnt_q <= 3'd1) begin
        state_d = HZ_RUN;
        bcnt_d  = '0;
      end
    end else if (luHit) begin
      ctrl.pcStall   = 1'b1;
      ctrl.ifIdStall = 1'b1;
      ctrl.idExFlush = 1'b1;
      if (LU_BUBBLES > 1) begin
        state_d = HZ_LU_STALL;
        bcnt_d  = 3'(LU_BUBBLES - 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HZ_RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign hz.PC_stall_o     = ctrl.pcStall;
  assign hz.IF_ID_stall_o  = ctrl.ifIdStall;
  assign hz.IF_ID_flush_o  = ctrl.ifIdFlush;
  assign hz.ID_EX_flush_o  = ctrl.idExFlush;
  assign hz.EX_MEM_stall_o = ctrl.exMemStall;

`ifdef HAZARD_PERF_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ctrl.pcStall),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ctrl.ifIdFlush),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances (LU_BUBBLES=1/CNT_W=4 and
// LU_BUBBLES=3/CNT_W=16) share stimulus; counters are checked when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl_unit;

  // Control bundle order: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LU   = 5'b11010;
  localparam logic [4:0] BR   = 5'b00110;
  localparam logic [4:0] FRZ  = 5'b11001;

  typedef struct {
    string      name;
    logic [4:0] expA;
    logic [4:0] expB;
    bit         chkCnt;
    int         sA, fA, sB, fB;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       memRead, useRT, br, memReq, memReady;
  logic [4:0] exRt, rs, rt;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.ADDR_W(5)) ifA ();
  hazard_ctrl_unit_if #(.ADDR_W(5)) ifB ();

  assign ifA.IF_ID_RSaddr_i  = rs;
  assign ifA.IF_ID_RTaddr_i  = rt;
  assign ifA.IF_ID_useRT_i   = useRT;
  assign ifA.ID_EX_RTaddr_i  = exRt;
  assign ifA.ID_EX_MemRead_i = memRead;
  assign ifA.branch_taken_i  = br;
  assign ifA.mem_req_i       = memReq;
  assign ifA.mem_ready_i     = memReady;
  assign ifB.IF_ID_RSaddr_i  = rs;
  assign ifB.IF_ID_RTaddr_i  = rt;
  assign ifB.IF_ID_useRT_i   = useRT;
  assign ifB.ID_EX_RTaddr_i  = exRt;
  assign ifB.ID_EX_MemRead_i = memRead;
  assign ifB.branch_taken_i  = br;
  assign ifB.mem_req_i       = memReq;
  assign ifB.mem_ready_i     = memReady;

`ifdef HAZARD_PERF_EN
  logic [3:0]  stallCntA, flushCntA;
  logic [15:0] stallCntB, flushCntB;
`endif

  hazard_ctrl_unit #(.ADDR_W(5), .LU_BUBBLES(1), .CNT_W(4)) dutA (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (ifA)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o (stallCntA),
    .flush_cnt_o (flushCntA)
`endif
  );

  hazard_ctrl_unit #(.ADDR_W(5), .LU_BUBBLES(3), .CNT_W(16)) dutB (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (ifB)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o (stallCntB),
    .flush_cnt_o (flushCntB)
`endif
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One vector per cycle: inputs change 1ns after the rising edge, expectation queued.
  task automatic applyStimulus(input string name, input logic rstN, input logic mr,
                               input logic [4:0] eRt, input logic [4:0] sRs, input logic [4:0] sRt,
                               input logic uRt, input logic b, input logic mReq, input logic mRdy,
                               input logic [4:0] eA, input logic [4:0] eB);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstN; memRead = mr; exRt = eRt; rs = sRs; rt = sRt;
    useRT = uRt; br = b; memReq = mReq; memReady = mRdy;
    e.name = name; e.expA = eA; e.expB = eB; e.chkCnt = 1'b0;
    e.sA = 0; e.fA = 0; e.sB = 0; e.fB = 0;
    expQ.push_back(e);
  endtask

  task automatic applyIdle(input string name, input logic [4:0] eA, input logic [4:0] eB);
    applyStimulus(name, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, eA, eB);
  endtask

  task automatic applyHit(input string name, input logic [4:0] eA, input logic [4:0] eB);
    applyStimulus(name, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, eA, eB);
  endtask

  task automatic applyCounterCheck(input string name, input int sA, input int fA,
                                   input int sB, input int fB);
    applyIdle(name, NONE, NONE);
    expQ[expQ.size()-1].chkCnt = 1'b1;
    expQ[expQ.size()-1].sA = sA;
    expQ[expQ.size()-1].fA = fA;
    expQ[expQ.size()-1].sB = sB;
    expQ[expQ.size()-1].fB = fB;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput({e.name, "/A"}, {11'd0, ifA.PC_stall_o, ifA.IF_ID_stall_o, ifA.IF_ID_flush_o,
                  ifA.ID_EX_flush_o, ifA.EX_MEM_stall_o}, {11'd0, e.expA});
      checkOutput({e.name, "/B"}, {11'd0, ifB.PC_stall_o, ifB.IF_ID_stall_o, ifB.IF_ID_flush_o,
                  ifB.ID_EX_flush_o, ifB.EX_MEM_stall_o}, {11'd0, e.expB});
`ifdef HAZARD_PERF_EN
      if (e.chkCnt) begin
        checkOutput({e.name, "/stallA"}, {12'd0, stallCntA}, 16'(e.sA));
        checkOutput({e.name, "/flushA"}, {12'd0, flushCntA}, 16'(e.fA));
        checkOutput({e.name, "/stallB"}, stallCntB, 16'(e.sB));
        checkOutput({e.name, "/flushB"}, flushCntB, 16'(e.fB));
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; memRead = 1'b0; exRt = '0; rs = '0; rt = '0;
    useRT = 1'b0; br = 1'b0; memReq = 1'b0; memReady = 1'b0;
    repeat (2) @(posedge clk);

    // Hazard and freeze inputs present while reset is held: everything gated off
    applyStimulus("rst_gate", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, NONE, NONE);
    applyIdle("idle0", NONE, NONE);

    // Load-use on rs: one bubble for A, three for B
    applyHit("lu_rs", LU, LU);
    applyIdle("lu_rs+1", NONE, LU);
    applyIdle("lu_rs+2", NONE, LU);
    applyIdle("lu_rs+3", NONE, NONE);
    applyCounterCheck("cnt_lu", 1, 0, 3, 0);

    // No load, $zero destination, unused rt, then a real rt hit
    applyStimulus("no_load", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    applyStimulus("zero_reg", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    applyStimulus("rt_unused", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    applyStimulus("rt_used", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    applyIdle("rt_used+1", NONE, LU);
    applyIdle("rt_used+2", NONE, LU);
    applyIdle("rt_used+3", NONE, NONE);

    // Freeze during B's second bubble stretches its window to 5 stall cycles
    applyStimulus("rst2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    applyHit("frz_hit", LU, LU);
    applyStimulus("frz_1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    applyStimulus("frz_2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    applyIdle("frz_b2", NONE, LU);
    applyIdle("frz_b3", NONE, LU);
    applyIdle("frz_done", NONE, NONE);
    applyCounterCheck("cnt_frz", 3, 0, 5, 0);

    // Branch beats a simultaneous load-use, and aborts an ongoing stall
    applyStimulus("br_lu", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
    applyIdle("br_lu+1", NONE, NONE);
    applyHit("br_stall_hit", LU, LU);
    applyStimulus("br_abort", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
    applyIdle("br_abort+1", NONE, NONE);
    applyCounterCheck("cnt_br", 4, 2, 6, 2);

    // Branch held through a 4-cycle freeze: flush lands when memory becomes ready
    for (int i = 0; i < 4; i++)
      applyStimulus("frz_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, FRZ);
    applyStimulus("frz_br_rdy", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR, BR);
    applyIdle("frz_br+1", NONE, NONE);
    applyCounterCheck("cnt_frz_br", 8, 3, 10, 3);

    // Reset asserted mid-stall kills outputs immediately and returns B to RUN
    applyHit("rst_mid_hit", LU, LU);
    applyStimulus("rst_mid", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    applyIdle("rst_mid_rel", NONE, NONE);
    applyCounterCheck("cnt_rst", 0, 0, 0, 0);

    // 20 freeze cycles saturate the 4-bit counter of A at 15
    for (int i = 0; i < 20; i++)
      applyStimulus("sat_frz", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    applyCounterCheck("cnt_sat", 15, 0, 20, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage pipelined CPU, sitting beside the ID stage and driving the stall and flush controls of PC, IF/ID, ID/EX and EX/MEM. It generalises load-use detection in four ways:
- configurable load-use bubble count;
- `$zero` exclusion;
- taken-branch flush priority;
- whole-pipe freeze while a multi-cycle data-memory access is outstanding.

Stall decisions are combinational from current inputs plus registered FSM state, so a bubble takes effect in the same cycle the hazard is seen.

## Interface
- `ADDR_W`, default 5: register-address width.
- `LU_BUBBLES`, default 1: bubbles inserted per load-use hazard, legal range 1..7.
- `CNT_W`, default 16: width of the performance counters.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-low.
- `IF_ID_RSaddr_i`, input, `ADDR_W`: rs of the instruction in ID.
- `IF_ID_RTaddr_i`, input, `ADDR_W`: rt of the instruction in ID.
- `IF_ID_useRT_i`, input, 1: the ID instruction reads rt as a source.
- `ID_EX_RTaddr_i`, input, `ADDR_W`: destination of the instruction in EX.
- `ID_EX_MemRead_i`, input, 1: the EX instruction is a load.
- `branch_taken_i`, input, 1: EX resolved a taken branch or jump.
- `mem_req_i`, input, 1: MEM stage has a data-memory access this cycle.
- `mem_ready_i`, input, 1: data memory completes the access this cycle.
- `PC_stall_o`, output, 1: hold PC.
- `IF_ID_stall_o`, output, 1: hold IF/ID.
- `IF_ID_flush_o`, output, 1: load a NOP into IF/ID.
- `ID_EX_flush_o`, output, 1: load a bubble (all control bits 0) into ID/EX.
- `EX_MEM_stall_o`, output, 1: hold EX/MEM and MEM/WB (freeze).
- `stall_cnt_o`, output, `CNT_W`: stall-cycle count; present only with `HAZARD_PERF_EN`.
- `flush_cnt_o`, output, `CNT_W`: flush-event count; present only with `HAZARD_PERF_EN`.

## Operation
- **Internal signals.**
  - lu_hit = `ID_EX_MemRead_i` && `ID_EX_RTaddr_i` != 0 && (`ID_EX_RTaddr_i` == `IF_ID_RSaddr_i` || (`IF_ID_useRT_i` && `ID_EX_RTaddr_i` == `IF_ID_RTaddr_i`)).
  - freeze = `mem_req_i` && !`mem_ready_i`.
- **FSM states.** RUN and LU_STALL, plus a 3-bit bubble counter `bcnt`.
- **Output priority**, highest first:
  1. freeze: `PC_stall_o`, `IF_ID_stall_o` and `EX_MEM_stall_o` = 1, both flushes = 0. State, `bcnt` and all pending events hold; `branch_taken_i` is ignored this cycle.
  2. `branch_taken_i`: `IF_ID_flush_o` = `ID_EX_flush_o` = 1 and all stalls = 0. Any LU_STALL is aborted: next state RUN, `bcnt` = 0.
  3. LU_STALL: `PC_stall_o` = `IF_ID_stall_o` = `ID_EX_flush_o` = 1. `bcnt` decrements; when `bcnt` == 1 this is the last bubble and next state is RUN.
  4. RUN with lu_hit: same outputs as priority 3. If `LU_BUBBLES` > 1, next state LU_STALL with `bcnt` = `LU_BUBBLES`-1; otherwise stay in RUN.
  5. Otherwise: all outputs 0.
- **lu_hit in LU_STALL** is not re-evaluated. ID/EX already holds a bubble; the ID instruction is re-checked on return to RUN.
- **Taken branch and lu_hit in the same cycle:** the branch wins. The ID instruction is wrong-path and is flushed, not stalled.
- **Reset (`rst_i` = 0):**
  - state RUN, `bcnt` = 0, counters = 0, all outputs 0;
  - the freeze term is gated off during reset.
- **Reset mid-stall** aborts the stall immediately (asynchronous).
- **Counters** (`HAZARD_PERF_EN` only):
  - `stall_cnt_o` +1 on each cycle with `PC_stall_o` = 1;
  - `flush_cnt_o` +1 on each cycle with `IF_ID_flush_o` = 1;
  - both saturate at all-ones and do not wrap.

## Timing
- Detection-to-control latency is 0 cycles: outputs are valid in the same cycle as the inputs.
- Registered state updates at the rising edge.
- One load-use hazard gives exactly `LU_BUBBLES` consecutive cycles of `PC_stall_o` = 1, excluding freeze cycles. Freeze cycles extend the stall window without consuming `bcnt`.
- Branch flush lasts exactly 1 cycle per `branch_taken_i` cycle.
- Freeze lasts as long as `mem_req_i` && !`mem_ready_i`. In the cycle `mem_ready_i` rises, normal priority resumes.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt_o` and `flush_cnt_o` ports and their counter registers exist.
- `HAZARD_PERF_EN` undefined:
  - the ports and registers are absent;
  - all other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state encoding (`HZ_RUN`, `HZ_LU_STALL`);
  - the `$zero` constant `REG_ZERO` = 0;
  - the default `ADDR_W`.
- One sub-module, `hazard_sat_counter`: `CNT_W`-wide saturating counter with `inc` input and asynchronous active-low reset. It is instantiated twice under `HAZARD_PERF_EN`.

## Test plan
- **Load-use on rs**, `LU_BUBBLES` = 1: MemRead = 1, EX rt = 5, ID rs = 5 → stalls and `ID_EX_flush_o` = 1 for exactly 1 cycle, then 0.
- **`$zero` and unused rt:**
  - EX rt = 0 matching ID rs = 0 → no stall;
  - EX rt = 7, ID rt = 7 with `IF_ID_useRT_i` = 0 → no stall.
- **`LU_BUBBLES` = 3:** hit → 3 stall cycles. If a 2-cycle freeze occurs in the second stall cycle, the stall window is 5 cycles and `stall_cnt_o` = 5.
- **Branch vs load-use:**
  - branch_taken and lu_hit in the same cycle → both flushes 1, `PC_stall_o` = 0;
  - branch during LU_STALL → stall aborted, RUN next cycle.
- **Freeze with pending branch:** `mem_req_i` = 1, `mem_ready_i` = 0 for 4 cycles with `branch_taken_i` held → 4 freeze cycles with no flush; the flush occurs in the cycle `mem_ready_i` = 1.
- **Reset mid-stall and saturation:**
  - `rst_i` low during LU_STALL → outputs 0 asynchronously, state RUN after release;
  - with `CNT_W` = 4, 20 stall cycles → `stall_cnt_o` = 15.
